// File: rtl/icache_responder_if.sv
// Fetch-side and fill-side signal bundle for icache_responder.
// The cache is the slave; the core fetch stage and backing memory together form the master.
interface icache_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] read_addr;
    logic              inv;
    logic [DATA_W-1:0] read_data;
    logic              data_ready;
    logic              busy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req_valid,
        input  read_addr,
        input  inv,
        input  mem_rdata,
        input  mem_ack,
        output read_data,
        output data_ready,
        output busy,
        output mem_req,
        output mem_addr
    );

    modport master (
        output req_valid,
        output read_addr,
        output inv,
        output mem_rdata,
        output mem_ack,
        input  read_data,
        input  data_ready,
        input  busy,
        input  mem_req,
        input  mem_addr
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache responder with req/ack miss fill.
// Optional hit/miss statistics counters are enabled by defining ICACHE_RESPONDER_STATS_EN.
module icache_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    icache_responder_if.slave   bus
`ifdef ICACHE_RESPONDER_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] read_data_reg, read_data_next;
    logic              data_ready_reg, data_ready_next;
    logic              mem_req_reg, mem_req_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [LINES-1:0]  valid_reg, valid_next;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  tag_rd_reg;
    logic [DATA_W-1:0] data_rd_reg;

    logic [INDEX_W-1:0] req_idx;
    logic [INDEX_W-1:0] lookup_idx;
    logic [TAG_W-1:0]   lookup_tag;
    logic               accept;
    logic               hit;
    logic               fill_we;

    assign req_idx    = bus.read_addr[INDEX_W-1:0];
    assign lookup_idx = addr_reg[INDEX_W-1:0];
    assign lookup_tag = addr_reg[ADDR_W-1:INDEX_W];
    assign accept     = (state_reg == ST_IDLE) && bus.req_valid;
    // Tag/data were read on the accept edge; valid is read live so an inv
    // landing with the request is already visible here.
    assign hit        = valid_reg[lookup_idx] && (tag_rd_reg == lookup_tag);
    assign fill_we    = (state_reg == ST_FILL) && bus.mem_ack;

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        read_data_next  = read_data_reg;
        data_ready_next = 1'b0;
        mem_req_next    = mem_req_reg;
        mem_addr_next   = mem_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_next  = bus.read_addr;
                    state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    read_data_next  = data_rd_reg;
                    data_ready_next = 1'b1;
                    state_next      = ST_IDLE;
                end else begin
                    mem_req_next  = 1'b1;
                    mem_addr_next = addr_reg;
                    state_next    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (bus.mem_ack) begin
                    read_data_next  = bus.mem_rdata;
                    data_ready_next = 1'b1;
                    mem_req_next    = 1'b0;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    // A fill's own line stays valid even when inv arrives on the same edge.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            assign valid_next[gi] = (fill_we && (lookup_idx == INDEX_W'(gi))) ? 1'b1 :
                                    bus.inv ? 1'b0 : valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            read_data_reg  <= '0;
            data_ready_reg <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            valid_reg      <= '0;
        end else if (clk_en) begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            read_data_reg  <= read_data_next;
            data_ready_reg <= data_ready_next;
            mem_req_reg    <= mem_req_next;
            mem_addr_reg   <= mem_addr_next;
            valid_reg      <= valid_next;
        end
    end

    // Tag/data storage is never reset; reads are registered on request accept.
    always_ff @(posedge clk) begin
        if (rst && clk_en) begin
            if (fill_we) begin
                tag_mem[lookup_idx]  <= lookup_tag;
                data_mem[lookup_idx] <= bus.mem_rdata;
            end
            if (accept) begin
                tag_rd_reg  <= tag_mem[req_idx];
                data_rd_reg <= data_mem[req_idx];
            end
        end
    end

    assign bus.read_data  = read_data_reg;
    assign bus.data_ready = data_ready_reg;
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_addr   = mem_addr_reg;

`ifdef ICACHE_RESPONDER_STATS_EN
    logic [15:0] hit_count_reg;
    logic [15:0] miss_count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (clk_en && (state_reg == ST_LOOKUP)) begin
            if (hit && (hit_count_reg != 16'hFFFF))
                hit_count_reg <= hit_count_reg + 16'd1;
            if (!hit && (miss_count_reg != 16'hFFFF))
                miss_count_reg <= miss_count_reg + 16'd1;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif
endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: expected words are queued at request time
// and popped when data_ready pulses; a small line model predicts hit or miss.
module tb_icache_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b1;

    icache_responder_if #(.ADDR_W(16), .DATA_W(32)) bus ();

`ifdef ICACHE_RESPONDER_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    icache_responder #(.ADDR_W(16), .DATA_W(32), .INDEX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .bus        (bus)
`ifdef ICACHE_RESPONDER_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb_q[$];

    bit          model_valid [16];
    logic [11:0] model_tag   [16];
    logic [31:0] model_data  [16];
    int          model_hits = 0;
    int          model_misses = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        foreach (model_valid[i]) model_valid[i] = 1'b0;
    endtask

    // inv_mode: 0 none, 1 inv with request, 2 inv with mem_ack, 3 inv during lookup
    task automatic fetch(input logic [15:0] addr, input logic [31:0] fill,
                         input int ack_delay, input int inv_mode, input string name);
        logic [3:0]  idx;
        logic [11:0] tag;
        bit          exp_hit;
        logic [31:0] exp_data;
        logic [31:0] want;
        int          edges;
        int          hold;
        int          exp_lat;
        bit          done;
        idx = addr[3:0];
        tag = addr[15:4];
        if (inv_mode == 1) model_clear();
        exp_hit  = model_valid[idx] && (model_tag[idx] == tag);
        exp_data = exp_hit ? model_data[idx] : fill;
        if (inv_mode == 3) model_clear();
        if (exp_hit) begin
            model_hits++;
        end else begin
            if (inv_mode == 2) model_clear();
            model_valid[idx] = 1'b1;
            model_tag[idx]   = tag;
            model_data[idx]  = fill;
            model_misses++;
        end
        exp_lat = exp_hit ? 2 : 3 + ack_delay;
        sb_q.push_back(exp_data);

        bus.req_valid = 1'b1;
        bus.read_addr = addr;
        bus.inv       = (inv_mode == 1);
        step();
        edges = 1;
        bus.req_valid = 1'b0;
        bus.read_addr = 16'($urandom);
        bus.inv       = (inv_mode == 3);
        hold = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            step();
            edges++;
            bus.inv       = 1'b0;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.data_ready === 1'b1) begin
                want = sb_q.pop_front();
                vectors++;
                if (bus.read_data !== want) begin
                    miscompares++;
                    $display("FAIL %s read_data: got %h expected %h", name, bus.read_data, want);
                end
                vectors++;
                if (edges != exp_lat) begin
                    miscompares++;
                    $display("FAIL %s latency: got %0d expected %0d", name, edges, exp_lat);
                end
                vectors++;
                if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s done_idle: mem_req %b busy %b expected 0 0", name, bus.mem_req, bus.busy);
                end
                done = 1'b1;
            end else if (bus.mem_req === 1'b1) begin
                if (hold == 0) begin
                    vectors++;
                    if (exp_hit) begin
                        miscompares++;
                        $display("FAIL %s hit_expected: got mem_req 1 expected 0", name);
                    end
                end
                vectors++;
                if (bus.mem_addr !== addr) begin
                    miscompares++;
                    $display("FAIL %s mem_addr: got %h expected %h", name, bus.mem_addr, addr);
                end
                if (hold == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = fill;
                    bus.inv       = (inv_mode == 2);
                end
                hold++;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no data_ready expected one", name);
            sb_q.delete();
        end
        step();
        vectors++;
        if (bus.data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s second_pulse: got data_ready %b expected 0", name, bus.data_ready);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        clk_en = 1'b0;
        step();
        step();
        vectors++;
        if ({bus.data_ready, bus.mem_req, bus.busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got dr/mreq/busy %b expected 000", {bus.data_ready, bus.mem_req, bus.busy});
        end
        vectors++;
        if (bus.read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_read_data: got %h expected 0", bus.read_data);
        end
        vectors++;
        if (bus.mem_addr !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr);
        end
`ifdef ICACHE_RESPONDER_STATS_EN
        vectors++;
        if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_stats: got %h/%h expected 0/0", hit_count, miss_count);
        end
`endif
        model_clear();
        model_hits   = 0;
        model_misses = 0;
        clk_en = 1'b1;
        rst    = 1'b1;
        step();
    endtask

    task automatic test_miss_hit();
        fetch(16'h000A, 32'h2001_0005, 2, 0, "miss_000A");
        fetch(16'h000A, 32'hDEAD_0000, 0, 0, "hit_000A");
    endtask

    task automatic test_conflict();
        fetch(16'h001A, 32'h1111_1111, 0, 0, "fill_001A");
        fetch(16'h000A, 32'h2001_0005, 1, 0, "conflict_000A");
        fetch(16'h0005, 32'h5555_0005, 0, 0, "fill_0005");
        fetch(16'h0005, 32'h0, 0, 0, "hit_0005");
    endtask

    task automatic test_inv();
        fetch(16'h000A, 32'h0, 0, 1, "inv_req_000A");
        fetch(16'h0005, 32'h5A5A_0005, 1, 2, "inv_ack_0005");
        fetch(16'h0005, 32'h0, 0, 0, "after_inv_ack_0005");
        fetch(16'h000A, 32'hAAAA_000A, 0, 0, "cleared_000A");
        fetch(16'h000A, 32'h0, 0, 3, "inv_lookup_000A");
        fetch(16'h000A, 32'hBBBB_000A, 0, 0, "after_inv_lookup_000A");
    endtask

    task automatic test_wrap();
        fetch(16'hFFFF, 32'hFFFF_0001, 0, 0, "fill_FFFF");
        fetch(16'hFFFF, 32'h0, 0, 0, "hit_FFFF");
        fetch(16'h000F, 32'h0F0F_000F, 1, 0, "conflict_000F");
        fetch(16'hFFFF, 32'hFFFF_0002, 0, 0, "refill_FFFF");
    endtask

    task automatic test_clk_en();
        logic [31:0] want;
        sb_q.push_back(32'hC0DE_0123);
        model_valid[3] = 1'b1;
        model_tag[3]   = 12'h012;
        model_data[3]  = 32'hC0DE_0123;
        model_misses++;
        bus.req_valid = 1'b1;
        bus.read_addr = 16'h0123;
        step();
        bus.req_valid = 1'b0;
        step();
        vectors++;
        if (bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL clk_en_mem_req: got %b expected 1", bus.mem_req);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hC0DE_0123;
        clk_en        = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({bus.data_ready, bus.mem_req, bus.busy} !== 3'b011) begin
                miscompares++;
                $display("FAIL clk_en_hold[%0d]: got dr/mreq/busy %b expected 011", i, {bus.data_ready, bus.mem_req, bus.busy});
            end
        end
        clk_en = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        vectors++;
        if (bus.data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clk_en_resume: got data_ready %b expected 1", bus.data_ready);
        end else begin
            want = sb_q.pop_front();
            vectors++;
            if (bus.read_data !== want) begin
                miscompares++;
                $display("FAIL clk_en_data: got %h expected %h", bus.read_data, want);
            end
        end
        step();
        vectors++;
        if (bus.data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL clk_en_second_pulse: got %b expected 0", bus.data_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_dr;
        logic [31:0] want;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(model_data[3]);
            model_hits++;
        end
        bus.req_valid = 1'b1;
        bus.read_addr = 16'h0123;
        for (int i = 1; i <= 6; i++) begin
            step();
            exp_dr = (i % 2 == 0);
            if (i == 6) bus.req_valid = 1'b0;
            vectors++;
            if (bus.data_ready !== exp_dr) begin
                miscompares++;
                $display("FAIL b2b_pulse[%0d]: got %b expected %b", i, bus.data_ready, exp_dr);
            end
            if (bus.data_ready === 1'b1 && sb_q.size() > 0) begin
                want = sb_q.pop_front();
                vectors++;
                if (bus.read_data !== want) begin
                    miscompares++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus.read_data, want);
                end
            end
        end
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (bus.data_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_hold_ready[%0d]: got %b expected 1", i, bus.data_ready);
            end
        end
        clk_en = 1'b1;
        step();
        vectors++;
        if (bus.data_ready !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_release: got dr %b busy %b expected 0 0", bus.data_ready, bus.busy);
        end
    endtask

    task automatic test_reset_fill();
        bus.req_valid = 1'b1;
        bus.read_addr = 16'h0456;
        step();
        bus.req_valid = 1'b0;
        step();
        vectors++;
        if (bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rstfill_mem_req: got %b expected 1", bus.mem_req);
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({bus.mem_req, bus.busy, bus.data_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL rstfill_drop: got mreq/busy/dr %b expected 000", {bus.mem_req, bus.busy, bus.data_ready});
        end
        rst = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (bus.data_ready !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rstfill_stray_ack[%0d]: got dr %b busy %b expected 0 0", i, bus.data_ready, bus.busy);
            end
        end
        bus.mem_ack = 1'b0;
        model_clear();
        model_hits   = 0;
        model_misses = 0;
        fetch(16'h0123, 32'h0123_4567, 1, 0, "rstfill_refetch_0123");
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.read_addr = '0;
        bus.inv       = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        test_reset();
        test_miss_hit();
        test_conflict();
        test_inv();
        test_wrap();
        test_clk_en();
        test_back_to_back();
        test_reset_fill();
`ifdef ICACHE_RESPONDER_STATS_EN
        vectors++;
        if (hit_count !== 16'(model_hits) || miss_count !== 16'(model_misses)) begin
            miscompares++;
            $display("FAIL stats: got %0d/%0d expected %0d/%0d", hit_count, miss_count, model_hits, model_misses);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
